// File: rtl/cve2_pkg.sv
// Shared types and constants for the fetch realigner and the RVC expander.
package cve2_pkg;

  // Major opcodes of the RV32 expansions produced by the compressed decoder.
  typedef enum logic [6:0] {
    OPCODE_LOAD   = 7'h03,
    OPCODE_OP_IMM = 7'h13,
    OPCODE_STORE  = 7'h23,
    OPCODE_OP     = 7'h33,
    OPCODE_LUI    = 7'h37,
    OPCODE_BRANCH = 7'h63,
    OPCODE_JALR   = 7'h67,
    OPCODE_JAL    = 7'h6f
  } opcode_e;

  // Zcb, quadrant 0, funct3 = 3'b100: sub-function in instr[12:10].
  localparam logic [2:0] ZcbQ0Lbu = 3'b000;
  localparam logic [2:0] ZcbQ0Lh  = 3'b001;  // instr[6] selects lh (1) or lhu (0)
  localparam logic [2:0] ZcbQ0Sb  = 3'b010;
  localparam logic [2:0] ZcbQ0Sh  = 3'b011;

  // Zcb, quadrant 1, funct6 = 6'b100111: {instr[12], instr[6:5]}.
  localparam logic [2:0] ZcbQ1Mul   = 3'b110;
  localparam logic [2:0] ZcbQ1Unary = 3'b111;

  // Zcb unary ops: sub-function in instr[4:2].
  localparam logic [2:0] ZcbUnZextB = 3'b000;
  localparam logic [2:0] ZcbUnSextB = 3'b001;
  localparam logic [2:0] ZcbUnZextH = 3'b010;
  localparam logic [2:0] ZcbUnSextH = 3'b011;
  localparam logic [2:0] ZcbUnNot   = 3'b101;

  // Upper bound on buffer depth; pointer and count widths are sized for it.
  localparam int unsigned RealignMaxHalfwords = 16;
  localparam int unsigned RealignPtrW         = 4;
  localparam int unsigned RealignCntW         = RealignPtrW + 1;

  typedef struct packed {
    logic [RealignCntW-1:0] count;
    logic [RealignPtrW-1:0] rd_ptr;
    logic [RealignPtrW-1:0] wr_ptr;
    logic [31:0]            head_addr;
    logic                   restart;
  } realign_state_t;

  typedef struct packed {
    logic [15:0] hw;
    logic        err;
  } realign_entry_t;

  // Circular pointer advance; inc is always below depth, so one wrap suffices.
  function automatic logic [RealignPtrW-1:0] realign_ptr_add(
    input logic [RealignPtrW-1:0] ptr,
    input logic [RealignCntW-1:0] inc,
    input logic [RealignCntW-1:0] depth
  );
    logic [RealignCntW-1:0] sum;
    sum = {1'b0, ptr} + inc;
    if (sum >= depth) begin
      sum = sum - depth;
    end
    return sum[RealignPtrW-1:0];
  endfunction

endpackage

// File: rtl/cve2_c_expander.sv
// Combinational RVC expander: one 16-bit halfword to its RV32 equivalent plus an illegal flag.
module cve2_c_expander
  import cve2_pkg::*;
#(
  parameter bit ZcbEn = 1'b0
) (
  input  logic [15:0] instr_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  logic [15:0] c;
  logic [4:0]  rs1p;
  logic [4:0]  rs2p;
  logic        illegal;
  logic        is_zcb;

  assign c    = instr_i;
  assign rs1p = {2'b01, c[9:7]};  // rd'/rs1' field
  assign rs2p = {2'b01, c[4:2]};  // rd'/rs2' field

  // Decode quadrant/funct3 and build the 32-bit expansion.
  always_comb begin
    instr_o = {16'h0000, c};
    illegal = 1'b0;
    is_zcb  = 1'b0;
    unique case (c[1:0])
      2'b00: begin
        unique case (c[15:13])
          3'b000: begin  // c.addi4spn
            instr_o = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'h02, 3'b000, rs2p,
                       OPCODE_OP_IMM};
            illegal = (c[12:5] == 8'h00);
          end
          3'b010: begin  // c.lw
            instr_o = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rs2p, OPCODE_LOAD};
          end
          3'b110: begin  // c.sw
            instr_o = {5'b0, c[5], c[12], rs2p, rs1p, 3'b010, c[11:10], c[6], 2'b00,
                       OPCODE_STORE};
          end
          3'b100: begin
            is_zcb = 1'b1;
            unique case (c[12:10])
              ZcbQ0Lbu: instr_o = {10'b0, c[5], c[6], rs1p, 3'b100, rs2p, OPCODE_LOAD};
              ZcbQ0Lh: begin
                instr_o = {10'b0, c[5], 1'b0, rs1p, c[6] ? 3'b001 : 3'b101, rs2p, OPCODE_LOAD};
              end
              ZcbQ0Sb: instr_o = {7'b0, rs2p, rs1p, 3'b000, 3'b000, c[5], c[6], OPCODE_STORE};
              ZcbQ0Sh: begin
                instr_o = {7'b0, rs2p, rs1p, 3'b001, 3'b000, c[5], 1'b0, OPCODE_STORE};
                illegal = c[6];
              end
              default: illegal = 1'b1;
            endcase
          end
          default: illegal = 1'b1;  // FP loads/stores and reserved slots
        endcase
      end

      2'b01: begin
        unique case (c[15:13])
          3'b000: begin  // c.addi / c.nop
            instr_o = {{6{c[12]}}, c[12], c[6:2], c[11:7], 3'b000, c[11:7], OPCODE_OP_IMM};
          end
          3'b001, 3'b101: begin  // c.jal (rd = ra) / c.j (rd = zero)
            instr_o = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], {9{c[12]}},
                       4'b0000, ~c[15], OPCODE_JAL};
          end
          3'b010: begin  // c.li
            instr_o = {{6{c[12]}}, c[12], c[6:2], 5'h00, 3'b000, c[11:7], OPCODE_OP_IMM};
          end
          3'b011: begin
            if (c[11:7] == 5'h02) begin  // c.addi16sp
              instr_o = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'h02, 3'b000, 5'h02,
                         OPCODE_OP_IMM};
            end else begin  // c.lui
              instr_o = {{15{c[12]}}, c[6:2], c[11:7], OPCODE_LUI};
            end
            illegal = ({c[12], c[6:2]} == 6'h00);
          end
          3'b100: begin
            unique case (c[11:10])
              2'b00, 2'b01: begin  // c.srli / c.srai
                instr_o = {1'b0, c[10], 5'b0, c[6:2], rs1p, 3'b101, rs1p, OPCODE_OP_IMM};
                illegal = c[12];
              end
              2'b10: begin  // c.andi
                instr_o = {{6{c[12]}}, c[12], c[6:2], rs1p, 3'b111, rs1p, OPCODE_OP_IMM};
              end
              default: begin
                unique case ({c[12], c[6:5]})
                  3'b000: instr_o = {7'b0100000, rs2p, rs1p, 3'b000, rs1p, OPCODE_OP};
                  3'b001: instr_o = {7'b0000000, rs2p, rs1p, 3'b100, rs1p, OPCODE_OP};
                  3'b010: instr_o = {7'b0000000, rs2p, rs1p, 3'b110, rs1p, OPCODE_OP};
                  3'b011: instr_o = {7'b0000000, rs2p, rs1p, 3'b111, rs1p, OPCODE_OP};
                  ZcbQ1Mul: begin
                    is_zcb  = 1'b1;
                    instr_o = {7'b0000001, rs2p, rs1p, 3'b000, rs1p, OPCODE_OP};
                  end
                  ZcbQ1Unary: begin
                    is_zcb = 1'b1;
                    unique case (c[4:2])
                      ZcbUnZextB: instr_o = {12'h0ff, rs1p, 3'b111, rs1p, OPCODE_OP_IMM};
                      ZcbUnSextB: instr_o = {12'h604, rs1p, 3'b001, rs1p, OPCODE_OP_IMM};
                      ZcbUnZextH: instr_o = {12'h080, rs1p, 3'b100, rs1p, OPCODE_OP};
                      ZcbUnSextH: instr_o = {12'h605, rs1p, 3'b001, rs1p, OPCODE_OP_IMM};
                      ZcbUnNot:   instr_o = {12'hfff, rs1p, 3'b100, rs1p, OPCODE_OP_IMM};
                      default:    illegal = 1'b1;
                    endcase
                  end
                  default: illegal = 1'b1;  // c.subw / c.addw are RV64 only
                endcase
              end
            endcase
          end
          default: begin  // c.beqz / c.bnez
            instr_o = {{4{c[12]}}, c[6:5], c[2], 5'h00, rs1p, 2'b00, c[13], c[11:10], c[4:3],
                       c[12], OPCODE_BRANCH};
          end
        endcase
      end

      2'b10: begin
        unique case (c[15:13])
          3'b000: begin  // c.slli
            instr_o = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], OPCODE_OP_IMM};
            illegal = c[12];
          end
          3'b010: begin  // c.lwsp
            instr_o = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'h02, 3'b010, c[11:7], OPCODE_LOAD};
            illegal = (c[11:7] == 5'h00);
          end
          3'b100: begin
            if (!c[12]) begin
              if (c[6:2] == 5'h00) begin  // c.jr
                instr_o = {12'h000, c[11:7], 3'b000, 5'h00, OPCODE_JALR};
                illegal = (c[11:7] == 5'h00);
              end else begin  // c.mv
                instr_o = {7'b0, c[6:2], 5'h00, 3'b000, c[11:7], OPCODE_OP};
              end
            end else if (c[6:2] == 5'h00) begin
              if (c[11:7] == 5'h00) begin  // c.ebreak
                instr_o = 32'h0010_0073;
              end else begin  // c.jalr
                instr_o = {12'h000, c[11:7], 3'b000, 5'h01, OPCODE_JALR};
              end
            end else begin  // c.add
              instr_o = {7'b0, c[6:2], c[11:7], 3'b000, c[11:7], OPCODE_OP};
            end
          end
          3'b110: begin  // c.swsp
            instr_o = {4'b0, c[8:7], c[12], c[6:2], 5'h02, 3'b010, c[11:9], 2'b00, OPCODE_STORE};
          end
          default: illegal = 1'b1;
        endcase
      end

      default: illegal = 1'b0;  // uncompressed; expansion unused
    endcase
  end

  assign illegal_o = illegal | (is_zcb & ~ZcbEn);

endmodule

// File: rtl/cve2_instr_realigner.sv
// Fetch-side halfword buffer: realigns 16/32-bit instructions across fetch words and
// presents one (expanded) instruction per cycle to the ID stage.
module cve2_instr_realigner
  import cve2_pkg::*;
#(
  parameter int unsigned FetchWidth   = 32,
  parameter int unsigned BufHalfwords = 6,
  parameter bit          ZcbEn        = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  fetch_valid_i,
  output logic                  fetch_ready_o,
  input  logic [FetchWidth-1:0] fetch_rdata_i,
  input  logic [31:0]           fetch_addr_i,
  input  logic                  fetch_err_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_o,
  output logic [31:0]           instr_raw_o,
  output logic [31:0]           instr_addr_o,
  output logic                  instr_is_compressed_o,
  output logic                  instr_illegal_c_o,
  output logic                  instr_err_o
);

  localparam int unsigned NumHw     = FetchWidth / 16;
  // Top bit of the halfword-within-word offset in a byte address.
  localparam int unsigned AddrHiBit = $clog2(FetchWidth / 8) - 1;

  localparam logic [RealignCntW-1:0] Depth     = RealignCntW'(BufHalfwords);
  localparam logic [RealignCntW-1:0] NumHwCnt  = RealignCntW'(NumHw);
  localparam logic [RealignCntW-1:0] PushLimit = RealignCntW'(BufHalfwords - NumHw);

  realign_state_t state_q, state_d;
  // Sized for the maximum depth; entries at or above BufHalfwords are never written and
  // stay at their reset value.
  realign_entry_t buf_q [RealignMaxHalfwords];
  realign_entry_t buf_d [RealignMaxHalfwords];

  realign_entry_t         head_lo, head_hi;
  logic                   head_is_c, have_one, have_two;
  logic                   push, pop;
  logic [RealignCntW-1:0] skip, n_write, n_pop;
  logic [31:0]            raw;
  logic [31:0]            exp_instr;
  logic                   exp_illegal;

  assign head_lo = buf_q[state_q.rd_ptr];
  assign head_hi = buf_q[realign_ptr_add(state_q.rd_ptr, RealignCntW'(1), Depth)];

  assign head_is_c = (head_lo.hw[1:0] != 2'b11);
  assign have_one  = (state_q.count != '0);
  assign have_two  = (state_q.count >= RealignCntW'(2));

  // Registered count only: a same-cycle pop does not free space for a push.
  assign fetch_ready_o = !flush_i && (state_q.count <= PushLimit);
  // An errored lone low half is released without waiting for its upper half.
  assign instr_valid_o = !flush_i && have_one && (head_is_c || have_two || head_lo.err);

  assign push = fetch_valid_i && fetch_ready_o;
  assign pop  = instr_valid_o && instr_ready_i;

  // Halfwords below the restart address within the first word are dropped.
  assign skip    = state_q.restart ? RealignCntW'(fetch_addr_i[AddrHiBit:1]) : '0;
  assign n_write = push ? (NumHwCnt - skip) : '0;
  assign n_pop   = !pop ? '0 : ((head_is_c || !have_two) ? RealignCntW'(1) : RealignCntW'(2));

  cve2_c_expander #(
    .ZcbEn(ZcbEn)
  ) u_c_expander (
    .instr_i  (head_lo.hw),
    .instr_o  (exp_instr),
    .illegal_o(exp_illegal)
  );

  // Head instruction outputs.
  always_comb begin
    raw                   = head_is_c ? {16'h0000, head_lo.hw} : {head_hi.hw, head_lo.hw};
    instr_raw_o           = raw;
    instr_o               = head_is_c ? exp_instr : raw;
    instr_addr_o          = state_q.head_addr;
    instr_is_compressed_o = head_is_c;
    instr_illegal_c_o     = head_is_c && exp_illegal;
    instr_err_o           = head_lo.err || (!head_is_c && have_two && head_hi.err);
  end

  // Buffer writes, pointer/count/address bookkeeping and restart handling.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    if (flush_i) begin
      state_d.count   = '0;
      state_d.rd_ptr  = '0;
      state_d.wr_ptr  = '0;
      state_d.restart = 1'b1;
    end else begin
      if (push) begin
        for (int unsigned i = 0; i < NumHw; i++) begin
          if (RealignCntW'(i) >= skip) begin
            buf_d[realign_ptr_add(state_q.wr_ptr, RealignCntW'(i) - skip, Depth)] =
                '{hw: fetch_rdata_i[16*i +: 16], err: fetch_err_i};
          end
        end
        state_d.wr_ptr = realign_ptr_add(state_q.wr_ptr, n_write, Depth);
        if (state_q.restart) begin
          state_d.head_addr = fetch_addr_i;
          state_d.restart   = 1'b0;
        end
      end
      if (pop) begin
        state_d.rd_ptr    = realign_ptr_add(state_q.rd_ptr, n_pop, Depth);
        state_d.head_addr = state_q.head_addr + 32'({n_pop, 1'b0});
      end
      state_d.count = state_q.count + n_write - n_pop;
    end
  end

  // State and storage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '{count: '0, rd_ptr: '0, wr_ptr: '0, head_addr: 32'h0, restart: 1'b1};
      for (int unsigned i = 0; i < RealignMaxHalfwords; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

endmodule
